// File: rtl/me_window_feeder_pkg.sv
// Shared types and defaults for the motion-estimation window feeder.
// Contents:
//   pixel_t         8-bit luma sample
//   MACRO_DIM_DEF   default macroblock edge (pixels)
//   SEARCH_DIM_DEF  default search-window edge (pixels, <= 64)
//   feeder_state_t  feeder FSM states
//   is_last         compares a 6-bit row/col counter against edge-1
package me_pkg;

    typedef logic [7:0] pixel_t;

    localparam int MACRO_DIM_DEF  = 16;
    localparam int SEARCH_DIM_DEF = 48;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD_CPR = 3'd1,
        LOAD_SPR = 3'd2,
        START    = 3'd3,
        SERVE    = 3'd4
    } feeder_state_t;

    // True when a 6-bit load counter sits on the last index of an edge of length dim.
    function automatic logic is_last(input logic [5:0] idx, input int dim);
        return (idx == 6'(dim - 1));
    endfunction

endpackage

// File: rtl/me_window_feeder_ram.sv
// Pixel storage for the feeder: one search window and one macroblock.
// Ports:
//   clk, rst          clock, synchronous active-high reset (clears read registers only)
//   i_wr_mb/i_wr_win  write strobe into macroblock / window storage
//   i_wr_row/i_wr_col write coordinates, i_wr_data write pixel
//   i_rd_spr/i_rd_cpr row-read strobes (already qualified by the caller)
//   i_rd_addr         row index, i_rd_amt first SPR column
//   o_spr_row         registered SPR row (MACRO_DIM+1 pixels, zero-filled past the edge)
//   o_cpr_row         registered CPR row (MACRO_DIM pixels)
module me_window_ram
    import me_pkg::*;
#(
    parameter int MACRO_DIM  = MACRO_DIM_DEF,
    parameter int SEARCH_DIM = SEARCH_DIM_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_wr_mb,
    input  logic                     i_wr_win,
    input  logic [5:0]               i_wr_row,
    input  logic [5:0]               i_wr_col,
    input  pixel_t                   i_wr_data,
    input  logic                     i_rd_spr,
    input  logic                     i_rd_cpr,
    input  logic [5:0]               i_rd_addr,
    input  logic [5:0]               i_rd_amt,
    output pixel_t [MACRO_DIM:0]     o_spr_row,
    output pixel_t [MACRO_DIM-1:0]   o_cpr_row
);

    localparam int AW_W = $clog2(SEARCH_DIM);
    localparam int AW_M = $clog2(MACRO_DIM);

    pixel_t r_win [SEARCH_DIM][SEARCH_DIM];
    pixel_t r_mb  [MACRO_DIM][MACRO_DIM];

    pixel_t [MACRO_DIM:0]   w_spr_row;
    pixel_t [MACRO_DIM-1:0] w_cpr_row;
    logic                   w_spr_addr_ok;
    logic                   w_cpr_addr_ok;

    // Storage write port; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (i_wr_mb) begin
            r_mb[i_wr_row[AW_M-1:0]][i_wr_col[AW_M-1:0]] <= i_wr_data;
        end
        if (i_wr_win) begin
            r_win[i_wr_row[AW_W-1:0]][i_wr_col[AW_W-1:0]] <= i_wr_data;
        end
    end

    // Row-read muxes; 7-bit compares so a 64-pixel window still range-checks correctly.
    always_comb begin
        w_spr_row     = '0;
        w_cpr_row     = '0;
        w_spr_addr_ok = ({1'b0, i_rd_addr} < 7'(SEARCH_DIM));
        w_cpr_addr_ok = ({1'b0, i_rd_addr} < 7'(MACRO_DIM));
        for (int k = 0; k <= MACRO_DIM; k++) begin
            if (w_spr_addr_ok && (({1'b0, i_rd_amt} + 7'(k)) < 7'(SEARCH_DIM))) begin
                w_spr_row[k] = r_win[i_rd_addr[AW_W-1:0]][AW_W'(i_rd_amt + 6'(k))];
            end else begin
                w_spr_row[k] = 8'd0;
            end
        end
        for (int k = 0; k < MACRO_DIM; k++) begin
            if (w_cpr_addr_ok) begin
                w_cpr_row[k] = r_mb[i_rd_addr[AW_M-1:0]][k];
            end else begin
                w_cpr_row[k] = 8'd0;
            end
        end
    end

    // Output row registers: update only on a qualified request, otherwise hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_spr_row <= '0;
            o_cpr_row <= '0;
        end else begin
            if (i_rd_spr) begin
                o_spr_row <= w_spr_row;
            end
            if (i_rd_cpr) begin
                o_cpr_row <= w_cpr_row;
            end
        end
    end

endmodule

// File: rtl/me_window_feeder.sv
// Pixel-buffer responder for the motion-estimation core: loads a macroblock (CPR)
// then a search window (SPR) from a raster byte stream, starts the ME, serves its
// row requests with registered rows, and returns to idle when the result is consumed.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   wr_valid/wr_data/wr_ready     load stream handshake
//   me_readyi/me_start            ME idle indication / one-cycle start pulse
//   me_en_ram/me_en_spr/me_en_cpr row-read qualifiers
//   me_addr/me_amt                row index / first SPR column
//   pixel_spr_out/pixel_cpr_out   registered rows
//   me_done                       ME result consumed
//   busy                          not idle
//   rng_err                       sticky out-of-range row request flag
module me_window_feeder
    import me_pkg::*;
#(
    parameter int MACRO_DIM  = MACRO_DIM_DEF,
    parameter int SEARCH_DIM = SEARCH_DIM_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_valid,
    input  logic [7:0]             wr_data,
    output logic                   wr_ready,
    input  logic                   me_readyi,
    output logic                   me_start,
    input  logic                   me_en_ram,
    input  logic                   me_en_spr,
    input  logic                   me_en_cpr,
    input  logic [5:0]             me_addr,
    input  logic [5:0]             me_amt,
    output pixel_t [MACRO_DIM:0]   pixel_spr_out,
    output pixel_t [MACRO_DIM-1:0] pixel_cpr_out,
    input  logic                   me_done,
    output logic                   busy,
    output logic                   rng_err
);

    feeder_state_t r_state;
    feeder_state_t w_next;
    logic [5:0]    r_row;
    logic [5:0]    r_col;
    logic          r_rng_err;
    logic          w_xfer;
    logic          w_last_beat;
    int            w_dim;
    logic          w_rd_spr;
    logic          w_rd_cpr;

    assign wr_ready = (r_state == LOAD_CPR) || (r_state == LOAD_SPR);
    assign busy     = (r_state != IDLE);
    assign rng_err  = r_rng_err;
    assign w_xfer   = wr_valid & wr_ready;
    assign w_dim    = (r_state == LOAD_CPR) ? MACRO_DIM : SEARCH_DIM;
    assign w_last_beat = is_last(r_row, w_dim) & is_last(r_col, w_dim);
    assign w_rd_spr = (r_state == SERVE) & me_en_ram & me_en_spr;
    assign w_rd_cpr = (r_state == SERVE) & me_en_ram & me_en_cpr;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // FSM next state and the combinational start pulse.
    always_comb begin
        w_next   = r_state;
        me_start = 1'b0;
        case (r_state)
            IDLE: begin
                // The waking beat itself is not accepted: wr_ready is low here.
                if (wr_valid) begin
                    w_next = LOAD_CPR;
                end else begin
                    w_next = IDLE;
                end
            end
            LOAD_CPR: begin
                if (w_xfer && w_last_beat) begin
                    w_next = LOAD_SPR;
                end else begin
                    w_next = LOAD_CPR;
                end
            end
            LOAD_SPR: begin
                if (w_xfer && w_last_beat) begin
                    w_next = START;
                end else begin
                    w_next = LOAD_SPR;
                end
            end
            START: begin
                if (me_readyi) begin
                    me_start = 1'b1;
                    w_next   = SERVE;
                end else begin
                    w_next   = START;
                end
            end
            SERVE: begin
                if (me_done) begin
                    w_next = IDLE;
                end else begin
                    w_next = SERVE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Raster load counters; the final beat of each image wraps both back to 0,
    // so LOAD_SPR always starts at the origin.
    always_ff @(posedge clk) begin
        if (rst || !wr_ready) begin
            r_row <= 6'd0;
            r_col <= 6'd0;
        end else if (w_xfer) begin
            if (is_last(r_col, w_dim)) begin
                r_col <= 6'd0;
                r_row <= is_last(r_row, w_dim) ? 6'd0 : (r_row + 6'd1);
            end else begin
                r_col <= r_col + 6'd1;
            end
        end else begin
            r_row <= r_row;
            r_col <= r_col;
        end
    end

    // Sticky flag for row requests past the stored image; column overrun is not an error.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rng_err <= 1'b0;
        end else if ((w_rd_spr && ({1'b0, me_addr} >= 7'(SEARCH_DIM))) ||
                     (w_rd_cpr && ({1'b0, me_addr} >= 7'(MACRO_DIM)))) begin
            r_rng_err <= 1'b1;
        end else begin
            r_rng_err <= r_rng_err;
        end
    end

    me_window_ram #(
        .MACRO_DIM  (MACRO_DIM),
        .SEARCH_DIM (SEARCH_DIM)
    ) u_ram (
        .clk       (clk),
        .rst       (rst),
        .i_wr_mb   (w_xfer && (r_state == LOAD_CPR)),
        .i_wr_win  (w_xfer && (r_state == LOAD_SPR)),
        .i_wr_row  (r_row),
        .i_wr_col  (r_col),
        .i_wr_data (wr_data),
        .i_rd_spr  (w_rd_spr),
        .i_rd_cpr  (w_rd_cpr),
        .i_rd_addr (me_addr),
        .i_rd_amt  (me_amt),
        .o_spr_row (pixel_spr_out),
        .o_cpr_row (pixel_cpr_out)
    );

endmodule

// File: tb/tb_me_window_feeder.sv
// Directed bench for me_window_feeder with default dimensions (16 / 48).
// Load image: mb px = (16r+c)&255, win px = (48r+c)&255, i.e. both are the
// raster index modulo 256.
module tb_me_window_feeder;
    import me_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic              wr_valid;
    logic [7:0]        wr_data;
    logic              wr_ready;
    logic              me_readyi;
    logic              me_start;
    logic              me_en_ram;
    logic              me_en_spr;
    logic              me_en_cpr;
    logic [5:0]        me_addr;
    logic [5:0]        me_amt;
    pixel_t [16:0]     pixel_spr_out;
    pixel_t [15:0]     pixel_cpr_out;
    logic              me_done;
    logic              busy;
    logic              rng_err;

    int checks = 0;
    int errors = 0;
    logic [135:0] saved_spr;
    logic [127:0] saved_cpr;

    me_window_feeder dut (
        .clk           (clk),
        .rst           (rst),
        .wr_valid      (wr_valid),
        .wr_data       (wr_data),
        .wr_ready      (wr_ready),
        .me_readyi     (me_readyi),
        .me_start      (me_start),
        .me_en_ram     (me_en_ram),
        .me_en_spr     (me_en_spr),
        .me_en_cpr     (me_en_cpr),
        .me_addr       (me_addr),
        .me_amt        (me_amt),
        .pixel_spr_out (pixel_spr_out),
        .pixel_cpr_out (pixel_cpr_out),
        .me_done       (me_done),
        .busy          (busy),
        .rng_err       (rng_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [135:0] obs, input logic [135:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Expected SPR row: window ramp, zero past column 47 or row 47.
    function automatic logic [135:0] spr_exp(input int r, input int a);
        logic [135:0] v = '0;
        for (int k = 0; k < 17; k++) begin
            if (r < 48 && (a + k) < 48) v[8*k +: 8] = 8'((48 * r + a + k) & 255);
        end
        return v;
    endfunction

    // Expected CPR row: macroblock ramp, zero row past row 15.
    function automatic logic [135:0] cpr_exp(input int r);
        logic [135:0] v = '0;
        for (int k = 0; k < 16; k++) begin
            if (r < 16) v[8*k +: 8] = 8'((16 * r + k) & 255);
        end
        return v;
    endfunction

    // Stream npix accepted pixels starting at raster index 0, with occasional valid gaps.
    task automatic stream(input int npix);
        int   idx = 0;
        int   cyc = 0;
        logic acc;
        wr_valid = 1'b1;
        wr_data  = 8'd0;
        while (idx < npix && cyc < 4000) begin
            @(negedge clk);
            acc = wr_ready & wr_valid;
            @(posedge clk);
            #1;
            cyc++;
            if (acc) idx++;
            wr_data  = (idx < 256) ? 8'(idx) : 8'(idx - 256);
            wr_valid = ((cyc % 97) != 50);
        end
        wr_valid = 1'b0;
        chk("stream_count", 136'(idx), 136'(npix));
    endtask

    task automatic rd(input logic spr, input logic cpr, input logic en, input int a, input int amt);
        me_en_ram = en;
        me_en_spr = spr;
        me_en_cpr = cpr;
        me_addr   = 6'(a);
        me_amt    = 6'(amt);
        @(posedge clk);
        #1;
        me_en_ram = 1'b0;
        me_en_spr = 1'b0;
        me_en_cpr = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; wr_valid = 1'b0; wr_data = 8'd0; me_readyi = 1'b0;
        me_en_ram = 1'b0; me_en_spr = 1'b0; me_en_cpr = 1'b0;
        me_addr = 6'd0; me_amt = 6'd0; me_done = 1'b0;
        tick(); tick();
        rst = 1'b0;

        chk("rst_wr_ready", wr_ready, 1'b0);
        chk("rst_me_start", me_start, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_rng_err", rng_err, 1'b0);
        chk("rst_spr", pixel_spr_out, '0);
        chk("rst_cpr", pixel_cpr_out, '0);

        // Full load with ME not ready: no start while waiting.
        stream(256 + 2304);
        chk("start_busy", busy, 1'b1);
        chk("start_wr_ready", wr_ready, 1'b0);
        for (int i = 0; i < 5; i++) begin
            chk("start_wait_me_start", me_start, 1'b0);
            tick();
        end
        me_readyi = 1'b1;
        #1;
        chk("start_pulse", me_start, 1'b1);
        tick();
        chk("start_pulse_end", me_start, 1'b0);
        chk("serve_wr_ready", wr_ready, 1'b0);

        // SPR addr 1 amt 2 -> 50..66.
        rd(1'b1, 1'b0, 1'b1, 1, 2);
        chk("spr_1_2", pixel_spr_out, spr_exp(1, 2));
        chk("spr_1_2_rng", rng_err, 1'b0);
        // CPR addr 15 -> 240..255.
        rd(1'b0, 1'b1, 1'b1, 15, 0);
        chk("cpr_15", pixel_cpr_out, cpr_exp(15));
        // Simultaneous SPR 0/0 and CPR 0.
        rd(1'b1, 1'b1, 1'b1, 0, 0);
        chk("both_spr_0", pixel_spr_out, spr_exp(0, 0));
        chk("both_cpr_0", pixel_cpr_out, cpr_exp(0));
        // me_en_ram low: outputs hold.
        saved_spr = pixel_spr_out;
        saved_cpr = pixel_cpr_out;
        rd(1'b1, 1'b1, 1'b0, 5, 3);
        chk("hold_spr", pixel_spr_out, spr_exp(0, 0));
        chk("hold_cpr", pixel_cpr_out, cpr_exp(0));
        // Column overrun: 248..255 then zeros, no error.
        rd(1'b1, 1'b0, 1'b1, 47, 40);
        chk("spr_47_40", pixel_spr_out, spr_exp(47, 40));
        chk("spr_47_40_rng", rng_err, 1'b0);
        // Row out of range: zero row, sticky error.
        rd(1'b1, 1'b0, 1'b1, 50, 0);
        chk("spr_50", pixel_spr_out, '0);
        chk("spr_50_rng", rng_err, 1'b1);
        me_done = 1'b1;
        tick();
        me_done = 1'b0;
        chk("done_busy", busy, 1'b0);
        chk("done_rng_sticky", rng_err, 1'b1);
        // Read in IDLE is ignored.
        rd(1'b0, 1'b1, 1'b1, 15, 0);
        chk("idle_read_cpr", pixel_cpr_out, cpr_exp(0));

        // Reset clears flag and rows.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst2_rng_err", rng_err, 1'b0);
        chk("rst2_cpr", pixel_cpr_out, '0);

        // Reset in the middle of the window load (100 window pixels in).
        stream(256 + 100);
        chk("partial_busy", busy, 1'b1);
        chk("partial_wr_ready", wr_ready, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_wr_ready", wr_ready, 1'b0);
        chk("midrst_busy", busy, 1'b0);

        // Full reload with ME ready: start fires on entry to START.
        stream(256 + 2304);
        chk("reload_start", me_start, 1'b1);
        tick();
        chk("reload_serve_wr_ready", wr_ready, 1'b0);
        chk("reload_serve_busy", busy, 1'b1);
        rd(1'b1, 1'b0, 1'b1, 1, 2);
        chk("reload_spr_1_2", pixel_spr_out, spr_exp(1, 2));
        rd(1'b0, 1'b1, 1'b1, 15, 0);
        chk("reload_cpr_15", pixel_cpr_out, cpr_exp(15));
        chk("reload_serve_wr_ready2", wr_ready, 1'b0);
        me_done = 1'b1;
        tick();
        me_done = 1'b0;
        chk("reload_done_busy", busy, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
